// File: rtl/icache_pkg.sv
// Shared geometry constants, FSM encoding and word-select helper for the instruction cache.
package icache_pkg;
   localparam int LINES  = 8;
   localparam int WORDS  = 4;
   localparam int TAG_W  = 25;
   localparam int IDX_W  = 3;
   localparam int OFF_W  = 2;
   localparam int LINE_W = 32 * WORDS;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_e;

   function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line,
                                            input logic [OFF_W-1:0]  off);
      return line[{off, 5'b0} +: 32];
   endfunction
endpackage

// File: rtl/icache_if.sv
// Pipeline-side and memory-side signals of the instruction cache.
interface icache_if;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   modport slave (
      input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: combinational read of one line, synchronous write of one line.
// Only valid bits are reset; tag and data contents are don't-care until their line is filled.
module icache_line_array
   import icache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_vld,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_dat,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_dat
);
   logic [LINES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [TAG_W-1:0]  tag_d  [LINES];
   logic [LINE_W-1:0] data_q [LINES];
   logic [LINE_W-1:0] data_d [LINES];

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (wr_en) begin
         valid_d[wr_idx] = 1'b1;
         tag_d[wr_idx]   = wr_tag;
         data_d[wr_idx]  = wr_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign rd_vld = valid_q[rd_idx];
   assign rd_tag = tag_q[rd_idx];
   assign rd_dat = data_q[rd_idx];
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, 8 lines x 4 words; hits answer combinationally.
// Defining ICACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module icache
   import icache_pkg::*;
(
   input  logic clk,
   input  logic rst,
   icache_if.slave bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);
   state_e            state_q, state_d;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [OFF_W-1:0]  req_off;
   logic              line_vld;
   logic [TAG_W-1:0]  line_tag;
   logic [LINE_W-1:0] line_dat;
   logic              hit, fill;
   logic              proc_stall, mem_read;
   logic [31:0]       proc_rdata;
   logic              unused_ok;

   assign req_tag = bus.proc_addr[29:5];
   assign req_idx = bus.proc_addr[4:2];
   assign req_off = bus.proc_addr[1:0];

   icache_line_array u_lines (
      .clk    (clk),
      .rst    (rst),
      .rd_idx (req_idx),
      .rd_vld (line_vld),
      .rd_tag (line_tag),
      .rd_dat (line_dat),
      .wr_en  (fill),
      .wr_idx (req_idx),
      .wr_tag (req_tag),
      .wr_dat (bus.mem_rdata)
   );

   assign hit = !rst && state_q == IDLE && bus.proc_read && line_vld && line_tag == req_tag;

   // Reset overrides everything so an in-flight fetch is dropped and a late mem_ready is ignored.
   always_comb begin
      state_d    = state_q;
      proc_stall = 1'b0;
      proc_rdata = '0;
      mem_read   = 1'b0;
      fill       = 1'b0;
      if (rst) begin
         state_d    = IDLE;
         proc_stall = bus.proc_read;
      end else begin
         case (state_q)
            IDLE: begin
               if (hit) begin
                  proc_rdata = word_sel(line_dat, req_off);
               end else if (bus.proc_read) begin
                  proc_stall = 1'b1;
                  state_d    = FETCH;
               end
            end
            FETCH: begin
               proc_stall = 1'b1;
               mem_read   = 1'b1;
               if (bus.mem_ready) begin
                  fill    = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   assign bus.proc_stall = proc_stall;
   assign bus.proc_rdata = proc_rdata;
   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = 1'b0;
   assign bus.mem_addr   = bus.proc_addr[29:2];
   assign bus.mem_wdata  = '0;
   assign unused_ok      = ^{bus.proc_write, bus.proc_wdata};

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (hit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
      if (state_q == IDLE && state_d == FETCH && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif
endmodule
